xdma_usr_irq_sched: RTL and testbench
=====================================

// Module: xdma_usr_irq_sched
// PURPOSE
//  Schedules user interrupts into the XDMA core's usr_irq_req/usr_irq_ack interface. Sits beside the
//  PCIe DMA endpoint wrapper in user_clk_o domain. Latches event pulses from NUM_SRC fabric sources,
//  round-robin arbitrates unmasked pending sources, and drives one outstanding request at a time.
//  Each request is held until ack or timeout, followed by an enforced hold-off gap.
// PARAMETERS
//  NUM_SRC      4     number of event sources (>=1)
//  NUM_IRQ      1     width of usr_irq_req/ack; source s drives line (s % NUM_IRQ)
//  ACK_TIMEOUT  1023  max cycles a request is held without ack (>=1)
//  GAP_CYCLES   4     idle cycles after each request before next arbitration (>=1)
// PORTS
//  user_clk_i      in   1                  clock (XDMA axi_aclk)
//  user_resetn_i   in   1                  asynchronous active-low reset
//  event_i         in   NUM_SRC            1-cycle event pulses, one per source
//  mask_i          in   NUM_SRC            1 = source masked; its pending bit is kept but not granted
//  msi_enable_i    in   1                  from XDMA; 0 blocks new grants
//  usr_irq_req_o   out  NUM_IRQ            to XDMA usr_irq_req
//  usr_irq_ack_i   in   NUM_IRQ            from XDMA usr_irq_ack (pulse)
//  pending_o       out  NUM_SRC            pending bit vector
//  cause_o         out  clog2(NUM_SRC)|1   source id of current/last grant
//  busy_o          out  1                  1 when state != IDLE
//  timeout_err_o   out  1                  sticky: a request timed out
//  clr_err_i       in   1                  clears timeout_err_o
// BEHAVIOUR
//  Reset (async, resetn=0): all outputs 0; state=IDLE; pending=0; rr pointer=0; counters=0.
//  Pending: pending[s] set on the edge after event_i[s]=1. It is cleared only on ack of a granted s.
//   If set and clear coincide, set wins. Repeated events while pending coalesce into one.
//  FSM (all outputs registered):
//   IDLE: if msi_enable_i && |(pending & ~mask_i), grant g = first eligible at or after rr_ptr
//     (wrapping). Latch cause_o=g and rr_ptr=(g+1)%NUM_SRC. Go to REQ.
//   REQ: usr_irq_req_o[g%NUM_IRQ]=1, other bits 0; cnt increments each cycle.
//     ack_i[g%NUM_IRQ]=1: drop req next edge, clear pending[g], go to GAP.
//     Else if cnt==ACK_TIMEOUT-1: drop req, set timeout_err_o, keep pending[g], go to GAP.
//     msi_enable_i or mask_i changes during REQ do not abort the request.
//   GAP: req=0 for GAP_CYCLES cycles, then IDLE.
//  Latency: event at edge t -> pending at t+1 -> req asserted after edge t+2 (IDLE, eligible).
//  Ack bits other than the active line, or any ack outside REQ, are ignored.
//  Ack and timeout in the same cycle: the ack wins; no error is set.
//  timeout_err_o: sticky until clr_err_i=1; if set and clr coincide, set wins.
//  Reset mid-REQ: req drops immediately (async); all pending events are lost.
//  cnt width clog2(ACK_TIMEOUT+1); gap counter width clog2(GAP_CYCLES+1); no wrap.
// TESTING
//  1. NUM_SRC=4: event_i=0001 at t, ack 3 cycles after req rises -> req high t+2..t+4;
//     pending[0] clears; cause_o=0; busy_o low after GAP.
//  2. event_i=0101 same cycle, acks immediate -> grants 0 then 2 with >=GAP_CYCLES idle between;
//     next event 0001 after rr_ptr=3 -> grant 0.
//  3. event_i[1] pulsed 3x during its own REQ -> pending[1] stays set at ack; exactly one more req follows.
//  4. ACK_TIMEOUT=8, no ack -> req high exactly 8 cycles; timeout_err_o=1; pending kept; retry after GAP;
//     clr_err_i clears the error.
//  5. msi_enable_i=0 or mask_i[s]=1 with pending[s] -> no req;
//     re-enable/unmask -> req within 1 cycle of entering IDLE.
//  6. Assert user_resetn_i=0 mid-REQ -> req, pending, busy_o, timeout_err_o all 0 immediately.

Source files
------------

// File: rtl/xdma_usr_irq_sched.sv
// -----------------------------------------------------------------------------
// xdma_usr_irq_sched
//
// Purpose:
//   Schedules user interrupts into the XDMA core's usr_irq_req/usr_irq_ack
//   handshake. Event pulses from NUM_SRC fabric sources are latched into a
//   pending vector. Unmasked pending sources are arbitrated round-robin, and
//   one request at a time is driven toward the core. Each request is held
//   until it is acknowledged or until it times out. After every request a
//   fixed hold-off gap is enforced before the next arbitration.
//
// Parameters:
//   NUM_SRC      number of event sources (>=1)
//   NUM_IRQ      width of usr_irq_req/ack; source s uses line (s % NUM_IRQ)
//   ACK_TIMEOUT  maximum cycles a request is held without ack (>=1)
//   GAP_CYCLES   idle cycles after each request before re-arbitration (>=1)
//
// Ports:
//   user_clk_i      in   clock (XDMA axi_aclk)
//   user_resetn_i   in   asynchronous active-low reset
//   event_i         in   [NUM_SRC]   one-cycle event pulses, one per source
//   mask_i          in   [NUM_SRC]   1 = source masked (pending kept, not granted)
//   msi_enable_i    in   0 blocks new grants
//   usr_irq_req_o   out  [NUM_IRQ]   request lines to XDMA
//   usr_irq_ack_i   in   [NUM_IRQ]   ack pulses from XDMA
//   pending_o       out  [NUM_SRC]   pending bit vector
//   cause_o         out  [SRC_W]     source id of the current/last grant
//   busy_o          out  1 while the scheduler is not idle
//   timeout_err_o   out  sticky flag: a request timed out
//   clr_err_i       in   clears timeout_err_o
// -----------------------------------------------------------------------------
module xdma_usr_irq_sched #(
  parameter int NUM_SRC     = 4,
  parameter int NUM_IRQ     = 1,
  parameter int ACK_TIMEOUT = 1023,
  parameter int GAP_CYCLES  = 4,
  localparam int SRC_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               user_clk_i,
  input  logic               user_resetn_i,
  input  logic [NUM_SRC-1:0] event_i,
  input  logic [NUM_SRC-1:0] mask_i,
  input  logic               msi_enable_i,
  output logic [NUM_IRQ-1:0] usr_irq_req_o,
  input  logic [NUM_IRQ-1:0] usr_irq_ack_i,
  output logic [NUM_SRC-1:0] pending_o,
  output logic [SRC_W-1:0]   cause_o,
  output logic               busy_o,
  output logic               timeout_err_o,
  input  logic               clr_err_i
);

  localparam int LINE_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int CNT_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  // One extra bit so the rotated candidate index can exceed NUM_SRC-1
  // before being folded back into range.
  localparam int CAND_W = SRC_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_reg;
  logic [NUM_SRC-1:0] pending_reg;
  logic [SRC_W-1:0]   rr_ptr_reg;
  logic [SRC_W-1:0]   cause_reg;
  logic [NUM_IRQ-1:0] req_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [GAP_W-1:0]   gap_reg;
  logic               busy_reg;
  logic               err_reg;

  // ---------------------------------------------------------------------------
  // Source-to-line map (constant table)
  // ---------------------------------------------------------------------------
  logic [LINE_W-1:0] line_of [NUM_SRC];

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_line_map
      assign line_of[gi] = LINE_W'(gi % NUM_IRQ);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Round-robin search: first eligible source at or after rr_ptr, wrapping
  // ---------------------------------------------------------------------------
  logic [NUM_SRC-1:0] eligible;
  logic [CAND_W-1:0]  cand;
  logic               found;
  logic [SRC_W-1:0]   grant_idx;
  logic [SRC_W-1:0]   rr_next;
  logic [NUM_IRQ-1:0] grant_req;

  assign eligible = pending_reg & ~mask_i;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = {1'b0, rr_ptr_reg} + CAND_W'(i);
      if (cand >= CAND_W'(NUM_SRC)) begin
        cand = cand - CAND_W'(NUM_SRC);
      end
      if (!found && eligible[cand[SRC_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[SRC_W-1:0];
      end
    end
  end

  assign rr_next   = (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
  assign grant_req = NUM_IRQ'(1) << line_of[grant_idx];

  // ---------------------------------------------------------------------------
  // Request completion
  // ---------------------------------------------------------------------------
  // req_reg is one-hot on the active line during REQ. Masking the ack with it
  // therefore ignores ack bits on every other line.
  logic               ack_hit;
  logic               timeout_hit;
  logic [NUM_SRC-1:0] clr_vec;
  logic [NUM_SRC-1:0] pending_next;
  logic               err_next;

  assign ack_hit     = (state_reg == S_REQ) && (|(usr_irq_ack_i & req_reg));
  // The ack takes priority over a timeout that lands on the same cycle.
  assign timeout_hit = (state_reg == S_REQ) && !ack_hit &&
                       (cnt_reg == CNT_W'(ACK_TIMEOUT - 1));
  assign clr_vec     = ack_hit ? (NUM_SRC'(1) << cause_reg) : '0;
  // OR-ing new events in after the clear lets a coincident event win.
  assign pending_next = (pending_reg & ~clr_vec) | event_i;

  always_comb begin
    err_next = err_reg;
    if (timeout_hit) begin
      err_next = 1'b1;
    end else if (clr_err_i) begin
      err_next = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM and all registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge user_clk_i or negedge user_resetn_i) begin
    if (!user_resetn_i) begin
      state_reg   <= S_IDLE;
      pending_reg <= '0;
      rr_ptr_reg  <= '0;
      cause_reg   <= '0;
      req_reg     <= '0;
      cnt_reg     <= '0;
      gap_reg     <= '0;
      busy_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      err_reg     <= err_next;
      case (state_reg)
        S_IDLE: begin
          if (msi_enable_i && found) begin
            cause_reg  <= grant_idx;
            rr_ptr_reg <= rr_next;
            req_reg    <= grant_req;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= S_REQ;
          end
        end
        S_REQ: begin
          // Mask and MSI-enable changes do not abort an issued request.
          if (ack_hit || timeout_hit) begin
            req_reg   <= '0;
            gap_reg   <= '0;
            state_reg <= S_GAP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_reg == GAP_W'(GAP_CYCLES - 1)) begin
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end else begin
            gap_reg <= gap_reg + 1'b1;
          end
        end
        default: begin
          req_reg   <= '0;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign usr_irq_req_o = req_reg;
  assign pending_o     = pending_reg;
  assign cause_o       = cause_reg;
  assign busy_o        = busy_reg;
  assign timeout_err_o = err_reg;

endmodule

// File: tb/tb_xdma_usr_irq_sched.sv
// -----------------------------------------------------------------------------
// tb_xdma_usr_irq_sched
//   Directed bench for xdma_usr_irq_sched. Four sources, one IRQ line,
//   ACK_TIMEOUT=8, GAP_CYCLES=4. Inputs are driven 1 ns after the rising edge,
//   and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_xdma_usr_irq_sched;

  localparam int NUM_SRC     = 4;
  localparam int NUM_IRQ     = 1;
  localparam int ACK_TIMEOUT = 8;
  localparam int GAP_CYCLES  = 4;

  logic       clk;
  logic       resetn;
  logic [3:0] event_v;
  logic [3:0] mask_v;
  logic       msi_en;
  logic [0:0] req;
  logic [0:0] ack;
  logic [3:0] pending;
  logic [1:0] cause;
  logic       busy;
  logic       err;
  logic       clr_err;

  int checks;
  int errors;

  xdma_usr_irq_sched #(
    .NUM_SRC    (NUM_SRC),
    .NUM_IRQ    (NUM_IRQ),
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .user_clk_i   (clk),
    .user_resetn_i(resetn),
    .event_i      (event_v),
    .mask_i       (mask_v),
    .msi_enable_i (msi_en),
    .usr_irq_req_o(req),
    .usr_irq_ack_i(ack),
    .pending_o    (pending),
    .cause_o      (cause),
    .busy_o       (busy),
    .timeout_err_o(err),
    .clr_err_i    (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tick until a request is seen, or until the budget runs out.
  // n returns the number of ticks taken.
  task automatic wait_req(input string tag, input int budget, output int n);
    n = 0;
    while (req !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_req_seen"}, 32'(req), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 30) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic ack_now();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    int n;
    bit seen;
    checks  = 0;
    errors  = 0;
    resetn  = 1'b0;
    event_v = '0;
    mask_v  = '0;
    msi_en  = 1'b1;
    ack     = '0;
    clr_err = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_req", 32'(req), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cause", 32'(cause), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    resetn = 1'b1;

    // 1: single event, ack while req has been high for 3 cycles
    event_v = 4'b0001;
    tick();
    event_v = '0;
    check("t1_pending_set", 32'(pending), 32'h1);
    check("t1_req_not_yet", 32'(req), 32'd0);
    tick();
    check("t1_req_rise", 32'(req), 32'd1);
    check("t1_cause", 32'(cause), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    tick();
    check("t1_req_hold1", 32'(req), 32'd1);
    tick();
    check("t1_req_hold2", 32'(req), 32'd1);
    ack_now();
    check("t1_req_drop", 32'(req), 32'd0);
    check("t1_pending_clr", 32'(pending), 32'h0);
    tick();
    tick();
    tick();
    check("t1_busy_in_gap", 32'(busy), 32'd1);
    tick();
    check("t1_busy_after_gap", 32'(busy), 32'd0);

    // 2: fresh reset (rr_ptr=0), two events together, immediate acks
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    event_v = 4'b0101;
    tick();
    event_v = '0;
    check("t2_pending", 32'(pending), 32'h5);
    tick();
    check("t2_first_cause", 32'(cause), 32'd0);
    ack_now();
    check("t2_pending_after_ack0", 32'(pending), 32'h4);
    wait_req("t2_second", 20, n);
    check("t2_gap_ticks", 32'(n), 32'(GAP_CYCLES + 1));
    check("t2_second_cause", 32'(cause), 32'd2);
    ack_now();
    wait_idle("t2_b");
    event_v = 4'b0001;
    tick();
    event_v = '0;
    tick();
    check("t2_wrap_req", 32'(req), 32'd1);
    check("t2_wrap_cause", 32'(cause), 32'd0);
    ack_now();
    wait_idle("t2_c");

    // 3: repeated events on source 1 during its own request (rr_ptr=1)
    event_v = 4'b0010;
    tick();
    event_v = '0;
    tick();
    check("t3_cause", 32'(cause), 32'd1);
    event_v = 4'b0010;
    tick();
    event_v = '0;
    tick();
    event_v = 4'b0010;
    tick();
    event_v = '0;
    tick();
    event_v = 4'b0010;
    ack = 1'b1;
    tick();
    event_v = '0;
    ack = 1'b0;
    check("t3_req_drop", 32'(req), 32'd0);
    check("t3_pending_kept", 32'(pending), 32'h2);
    wait_req("t3_again", 20, n);
    check("t3_again_cause", 32'(cause), 32'd1);
    ack_now();
    check("t3_pending_clr", 32'(pending), 32'h0);
    wait_idle("t3");
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (req == 1'b1) seen = 1'b1;
    end
    check("t3_no_extra_req", 32'(seen), 32'd0);

    // 4: timeout on source 2 (rr_ptr=2)
    event_v = 4'b0100;
    tick();
    event_v = '0;
    tick();
    check("t4_cause", 32'(cause), 32'd2);
    n = 1;
    tick();
    while (req == 1'b1 && n < 20) begin
      n++;
      tick();
    end
    check("t4_req_high_cycles", 32'(n), 32'(ACK_TIMEOUT));
    check("t4_err_set", 32'(err), 32'd1);
    check("t4_pending_kept", 32'(pending), 32'h4);
    wait_req("t4_retry", 20, n);
    check("t4_retry_gap", 32'(n), 32'(GAP_CYCLES + 1));
    check("t4_retry_cause", 32'(cause), 32'd2);
    ack_now();
    check("t4_pending_clr", 32'(pending), 32'h0);
    check("t4_err_sticky", 32'(err), 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t4_err_cleared", 32'(err), 32'd0);
    wait_idle("t4");

    // Ack on the last cycle before timeout: ack wins, no error (rr_ptr=3)
    event_v = 4'b1000;
    tick();
    event_v = '0;
    tick();
    check("t4b_cause", 32'(cause), 32'd3);
    for (int i = 0; i < ACK_TIMEOUT - 1; i++) tick();
    check("t4b_req_still_high", 32'(req), 32'd1);
    ack_now();
    check("t4b_req_drop", 32'(req), 32'd0);
    check("t4b_no_err", 32'(err), 32'd0);
    check("t4b_pending_clr", 32'(pending), 32'h0);
    wait_idle("t4b");

    // 5: msi disabled, then masked source (rr_ptr=0)
    msi_en = 1'b0;
    event_v = 4'b0001;
    tick();
    event_v = '0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (req == 1'b1) seen = 1'b1;
    end
    check("t5_msi_blocks", 32'(seen), 32'd0);
    check("t5_msi_pending", 32'(pending), 32'h1);
    check("t5_msi_busy", 32'(busy), 32'd0);
    msi_en = 1'b1;
    tick();
    check("t5_msi_req", 32'(req), 32'd1);
    ack_now();
    wait_idle("t5_a");
    mask_v = 4'b0010;
    event_v = 4'b0010;
    tick();
    event_v = '0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (req == 1'b1) seen = 1'b1;
    end
    check("t5_mask_blocks", 32'(seen), 32'd0);
    check("t5_mask_pending", 32'(pending), 32'h2);
    mask_v = '0;
    tick();
    check("t5_unmask_req", 32'(req), 32'd1);
    check("t5_unmask_cause", 32'(cause), 32'd1);
    mask_v = 4'hF;
    msi_en = 1'b0;
    tick();
    tick();
    check("t5_no_abort", 32'(req), 32'd1);
    ack_now();
    check("t5_pending_clr", 32'(pending), 32'h0);
    msi_en = 1'b1;
    mask_v = '0;
    wait_idle("t5_b");

    // 6: reset in the middle of a request (rr_ptr=2)
    event_v = 4'b0100;
    tick();
    event_v = '0;
    tick();
    check("t6_req", 32'(req), 32'd1);
    n = 0;
    while (req == 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("t6_err_set", 32'(err), 32'd1);
    event_v = 4'b0001;
    tick();
    event_v = '0;
    wait_req("t6_retry", 20, n);
    check("t6_pending_before", 32'(pending), 32'h5);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_rst_req", 32'(req), 32'd0);
    check("t6_rst_pending", 32'(pending), 32'h0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_err", 32'(err), 32'd0);
    tick();
    resetn = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
